// File: rtl/alu_bist_driver.sv
// ALU built-in self-test initiator.
// Drives pseudo-random operand pairs across every {Opcode,ALUSel} combination and
// folds the ALU result plus flags into a 32-bit MISR signature, then reports
// pass/fail against a golden signature.
module alu_bist_driver #(
    parameter int          NUM_VECTORS   = 16,
    parameter int          SETTLE_CYCLES = 1,
    parameter logic [31:0] LFSR_SEED     = 32'hACE1_2345,
    parameter logic [31:0] GOLDEN_SIG    = 32'h0000_0000,
    localparam int         VW            = $clog2(NUM_VECTORS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [31:0]   signature,
    output logic [VW-1:0] vec_count,
    output logic [31:0]   DataA,
    output logic [31:0]   DataB,
    output logic [2:0]    Opcode,
    output logic          ALUSel,
    input  logic [31:0]   ALU_out,
    input  logic          Zero,
    input  logic          BGT,
    input  logic          BLT
);

    // Settle counter only needs to count 0..SETTLE_CYCLES-1.
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
    localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_DRIVE   = 3'd2;
    localparam logic [2:0] ST_CAPTURE = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    logic          r_rstMeta;
    logic          r_rstSync;
    logic [2:0]    r_state;
    logic [SW-1:0] r_settle;
    logic [31:0]   r_lfsr;
    logic [31:0]   r_dataA;
    logic [31:0]   r_dataB;
    logic [3:0]    r_combo;
    logic [31:0]   r_sig;
    logic [VW-1:0] r_vecCount;
    logic          r_done;
    logic          r_pass;

    logic [31:0]   w_lfsrNext1;
    logic [31:0]   w_lfsrNext2;
    logic [31:0]   w_captureData;
    logic [31:0]   w_sigNext;
    logic          w_startAccept;
    logic          w_inLoad;
    logic          w_inCapture;
    logic          w_settleLast;
    logic          w_lastCombo;
    logic          w_lastVector;
    logic          w_vecSaturated;

    // One Galois LFSR step.
    function automatic logic [31:0] lfsrStep(input logic [31:0] x);
        return (x >> 1) ^ (x[0] ? LFSR_TAPS : 32'h0);
    endfunction

    assign w_lfsrNext1    = lfsrStep(r_lfsr);
    assign w_lfsrNext2    = lfsrStep(w_lfsrNext1);
    assign w_captureData  = ALU_out ^ {29'b0, Zero, BGT, BLT};
    assign w_sigNext      = {r_sig[30:0], 1'b0} ^ (r_sig[31] ? MISR_POLY : 32'h0) ^ w_captureData;

    assign w_startAccept  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_inLoad       = (r_state == ST_LOAD);
    assign w_inCapture    = (r_state == ST_CAPTURE);
    assign w_settleLast   = (r_settle == SW'(SETTLE_CYCLES - 1));
    assign w_lastCombo    = (r_combo == 4'd15);
    assign w_lastVector   = ((32'(r_vecCount) + 32'd1) >= 32'(NUM_VECTORS));
    assign w_vecSaturated = (r_vecCount == VW'(NUM_VECTORS));

    // Reset synchronizer: assertion passes straight through, release is delayed two clocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rstMeta <= 1'b0;
            r_rstSync <= 1'b0;
        end else begin
            r_rstMeta <= 1'b1;
            r_rstSync <= r_rstMeta;
        end
    end

    // Sequencer: LOAD a pair, then DRIVE/CAPTURE each of the 16 combos, repeat per vector.
    always_ff @(posedge clk or negedge r_rstSync) begin
        if (!r_rstSync) begin
            r_state  <= ST_IDLE;
            r_settle <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_state  <= ST_DRIVE;
                    r_settle <= '0;
                end
                ST_DRIVE: begin
                    if (w_settleLast) begin
                        r_state <= ST_CAPTURE;
                    end else begin
                        r_settle <= r_settle + SW'(1);
                    end
                end
                ST_CAPTURE: begin
                    if (!w_lastCombo) begin
                        r_state  <= ST_DRIVE;
                        r_settle <= '0;
                    end else if (!w_lastVector) begin
                        r_state <= ST_LOAD;
                    end else begin
                        r_state <= ST_DONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Operand generation and combo stepping; operands only change in LOAD so they hold through DRIVE.
    always_ff @(posedge clk or negedge r_rstSync) begin
        if (!r_rstSync) begin
            r_lfsr  <= LFSR_SEED;
            r_dataA <= '0;
            r_dataB <= '0;
            r_combo <= '0;
        end else begin
            if (w_startAccept) begin
                r_lfsr <= LFSR_SEED;
            end else if (w_inLoad) begin
                r_dataA <= r_lfsr;
                r_dataB <= w_lfsrNext1;
                r_lfsr  <= w_lfsrNext2;
                r_combo <= '0;
            end else if (w_inCapture && !w_lastCombo) begin
                r_combo <= r_combo + 4'd1;
            end
        end
    end

    // Signature compression, progress count and the pass/fail verdict.
    always_ff @(posedge clk or negedge r_rstSync) begin
        if (!r_rstSync) begin
            r_sig      <= '0;
            r_vecCount <= '0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
        end else begin
            if (w_startAccept) begin
                r_sig      <= 32'hFFFF_FFFF;
                r_vecCount <= '0;
                r_done     <= 1'b0;
                r_pass     <= 1'b0;
            end else if (w_inCapture) begin
                r_sig <= w_sigNext;
                if (w_lastCombo && !w_vecSaturated) begin
                    r_vecCount <= r_vecCount + VW'(1);
                end
                if (w_lastCombo && w_lastVector) begin
                    r_done <= 1'b1;
                    r_pass <= (w_sigNext == GOLDEN_SIG);
                end
            end
        end
    end

    assign busy      = (r_state == ST_LOAD) || (r_state == ST_DRIVE) || (r_state == ST_CAPTURE);
    assign done      = r_done;
    assign pass      = r_pass;
    assign signature = r_sig;
    assign vec_count = r_vecCount;
    assign DataA     = r_dataA;
    assign DataB     = r_dataB;
    assign Opcode    = r_combo[3:1];
    assign ALUSel    = r_combo[0];

endmodule

// File: tb/tb_alu_bist_driver.sv
// Self-checking bench for alu_bist_driver using a behavioural ALU and a signature model.
module tb_alu_bist_driver;

    localparam logic [31:0] SEED = 32'hACE1_2345;

    // Reference LFSR step.
    function automatic logic [31:0] lfsrNext(input logic [31:0] x);
        return (x >> 1) ^ (x[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    // Behavioural ALU returning {result, Zero, BGT, BLT}, with optional faults.
    function automatic logic [34:0] aluModel(input logic [31:0] a, input logic [31:0] b,
                                             input logic [2:0] op, input logic sel,
                                             input logic stuck0, input logic zeroOne);
        logic [31:0] r;
        logic z, gt, lt;
        case (op)
            3'd0:    r = sel ? (a - b) : (a + b);
            3'd1:    r = sel ? (a | b) : (a & b);
            3'd2:    r = sel ? ~(a ^ b) : (a ^ b);
            3'd3:    r = sel ? (a >> b[4:0]) : (a << b[4:0]);
            3'd4:    r = sel ? a : (a + 32'd1);
            3'd5:    r = sel ? b : {31'b0, (a < b)};
            3'd6:    r = sel ? {b[15:0], a[15:0]} : {a[15:0], b[15:0]};
            default: r = sel ? ~b : ~a;
        endcase
        if (stuck0) r[0] = 1'b0;
        z  = (r == 32'h0) | zeroOne;
        gt = ($signed(a) > $signed(b));
        lt = ($signed(a) < $signed(b));
        return {r, z, gt, lt};
    endfunction

    // Expected final signature for an n-vector run through the behavioural ALU.
    function automatic logic [31:0] modelSig(input int n, input logic stuck0, input logic zeroOne);
        logic [31:0] sig, l, a, b, d;
        logic [34:0] res;
        logic [3:0]  c4;
        sig = 32'hFFFF_FFFF;
        l   = SEED;
        for (int v = 0; v < n; v++) begin
            a = l;
            b = lfsrNext(l);
            l = lfsrNext(b);
            for (int c = 0; c < 16; c++) begin
                c4  = 4'(c);
                res = aluModel(a, b, c4[3:1], c4[0], stuck0, zeroOne);
                d   = res[34:3] ^ {29'b0, res[2:0]};
                sig = ({sig[30:0], 1'b0} ^ (sig[31] ? 32'h04C1_1DB7 : 32'h0)) ^ d;
            end
        end
        return sig;
    endfunction

    localparam logic [31:0] GOLD1  = modelSig(1, 1'b0, 1'b0);
    localparam logic [31:0] GOLD16 = modelSig(16, 1'b0, 1'b0);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic rst1_n, start1, faultStuck, faultZero;
    logic rst3_n, start3;

    logic        busy1, done1, pass1, aluSel1, zero1, bgt1, blt1;
    logic [31:0] signature1, dataA1, dataB1, aluOut1;
    logic [0:0]  vecCount1;
    logic [2:0]  opcode1;

    logic        busy2, done2, pass2, aluSel2, zero2, bgt2, blt2;
    logic [31:0] signature2, dataA2, dataB2, aluOut2;
    logic [0:0]  vecCount2;
    logic [2:0]  opcode2;

    logic        busy3, done3, pass3, aluSel3, zero3, bgt3, blt3;
    logic [31:0] signature3, dataA3, dataB3, aluOut3;
    logic [4:0]  vecCount3;
    logic [2:0]  opcode3;

    assign {aluOut1, zero1, bgt1, blt1} = aluModel(dataA1, dataB1, opcode1, aluSel1, faultStuck, faultZero);
    assign {aluOut2, zero2, bgt2, blt2} = aluModel(dataA2, dataB2, opcode2, aluSel2, 1'b0, 1'b0);
    assign {aluOut3, zero3, bgt3, blt3} = aluModel(dataA3, dataB3, opcode3, aluSel3, 1'b0, 1'b0);

    alu_bist_driver #(.NUM_VECTORS(1), .SETTLE_CYCLES(1), .LFSR_SEED(SEED), .GOLDEN_SIG(GOLD1)) dut (
        .clk(clk), .rst_n(rst1_n), .start(start1), .busy(busy1), .done(done1), .pass(pass1),
        .signature(signature1), .vec_count(vecCount1), .DataA(dataA1), .DataB(dataB1),
        .Opcode(opcode1), .ALUSel(aluSel1), .ALU_out(aluOut1), .Zero(zero1), .BGT(bgt1), .BLT(blt1)
    );

    alu_bist_driver #(.NUM_VECTORS(1), .SETTLE_CYCLES(1), .LFSR_SEED(SEED), .GOLDEN_SIG(GOLD1 ^ 32'h1)) dutBad (
        .clk(clk), .rst_n(rst1_n), .start(start1), .busy(busy2), .done(done2), .pass(pass2),
        .signature(signature2), .vec_count(vecCount2), .DataA(dataA2), .DataB(dataB2),
        .Opcode(opcode2), .ALUSel(aluSel2), .ALU_out(aluOut2), .Zero(zero2), .BGT(bgt2), .BLT(blt2)
    );

    alu_bist_driver #(.NUM_VECTORS(16), .SETTLE_CYCLES(2), .LFSR_SEED(SEED), .GOLDEN_SIG(GOLD16)) dutLong (
        .clk(clk), .rst_n(rst3_n), .start(start3), .busy(busy3), .done(done3), .pass(pass3),
        .signature(signature3), .vec_count(vecCount3), .DataA(dataA3), .DataB(dataB3),
        .Opcode(opcode3), .ALUSel(aluSel3), .ALU_out(aluOut3), .Zero(zero3), .BGT(bgt3), .BLT(blt3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst1_n = 1'b0; rst3_n = 1'b0; start1 = 1'b0; start3 = 1'b0;
        faultStuck = 1'b0; faultZero = 1'b0;
        #2;
        checks++;
        if ({busy1, done1, pass1, signature1, vecCount1, dataA1, dataB1, opcode1, aluSel1} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got sig=%h A=%h B=%h busy=%b done=%b, required all zero",
                     signature1, dataA1, dataB1, busy1, done1);
        end
        checks++;
        if ({busy3, done3, pass3, signature3, vecCount3} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_long: got busy=%b done=%b sig=%h vc=%0d, required all zero",
                     busy3, done3, signature3, vecCount3);
        end
        tick(); tick();
        rst1_n = 1'b1; rst3_n = 1'b1;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if ({busy1, done1, signature1} !== '0) begin
            errors++;
            $display("[TB] FAIL idle_hold: got busy=%b done=%b sig=%h, required 0/0/0", busy1, done1, signature1);
        end
    endtask

    task automatic test_run_timing();
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        checks++;
        if (busy1 !== 1'b1 || signature1 !== 32'hFFFF_FFFF) begin
            errors++;
            $display("[TB] FAIL start_accept: got busy=%b sig=%h, required 1/ffffffff", busy1, signature1);
        end
        for (int t = 1; t <= 33; t++) begin
            tick();
            if (t == 1) begin
                checks++;
                if (dataA1 !== SEED || dataB1 !== lfsrNext(SEED)) begin
                    errors++;
                    $display("[TB] FAIL first_load: got A=%h B=%h, required %h %h",
                             dataA1, dataB1, SEED, lfsrNext(SEED));
                end
            end
            if (t <= 32) begin
                checks++;
                if ({opcode1, aluSel1} !== 4'((t - 1) / 2)) begin
                    errors++;
                    $display("[TB] FAIL combo_order t=%0d: got %0d, required %0d", t, {opcode1, aluSel1}, (t - 1) / 2);
                end
            end
            if (t == 32) begin
                checks++;
                if (done1 !== 1'b0 || busy1 !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL early_done: got done=%b busy=%b, required 0/1", done1, busy1);
                end
            end
        end
        checks++;
        if (done1 !== 1'b1 || busy1 !== 1'b0 || vecCount1 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL done_at_33: got done=%b busy=%b vc=%0d, required 1/0/1", done1, busy1, vecCount1);
        end
        checks++;
        if (signature1 !== GOLD1 || pass1 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL golden_pass: got sig=%h pass=%b, required %h/1", signature1, pass1, GOLD1);
        end
        checks++;
        if (signature2 !== GOLD1 || pass2 !== 1'b0 || done2 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL golden_mismatch: got sig=%h pass=%b done=%b, required %h/0/1",
                     signature2, pass2, done2, GOLD1);
        end
        checks++;
        if (opcode1 !== 3'd7 || aluSel1 !== 1'b1 || dataA1 !== SEED) begin
            errors++;
            $display("[TB] FAIL done_hold: got op=%0d sel=%b A=%h, required 7/1/%h", opcode1, aluSel1, dataA1, SEED);
        end
    endtask

    task automatic test_start_busy();
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int t = 1; t <= 33; t++) begin
            start1 = (t == 5 || t == 20);
            tick();
            start1 = 1'b0;
            if (t == 32) begin
                checks++;
                if (done1 !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL busy_start_early: got done=%b, required 0", done1);
                end
            end
        end
        checks++;
        if (done1 !== 1'b1 || signature1 !== GOLD1 || pass1 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL busy_start_ignored: got done=%b sig=%h pass=%b, required 1/%h/1",
                     done1, signature1, pass1, GOLD1);
        end
    endtask

    task automatic test_back_to_back();
        start1 = 1'b1;
        tick();
        checks++;
        if (busy1 !== 1'b1 || done1 !== 1'b0 || pass1 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL restart_clear: got busy=%b done=%b pass=%b, required 1/0/0", busy1, done1, pass1);
        end
        for (int t = 1; t <= 33; t++) tick();
        checks++;
        if (done1 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL held_start_done: got done=%b, required 1", done1);
        end
        tick();
        start1 = 1'b0;
        checks++;
        if (done1 !== 1'b0 || busy1 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL held_start_restart: got done=%b busy=%b, required 0/1", done1, busy1);
        end
        for (int t = 1; t <= 33; t++) tick();
        checks++;
        if (done1 !== 1'b1 || signature1 !== GOLD1) begin
            errors++;
            $display("[TB] FAIL held_start_rerun: got done=%b sig=%h, required 1/%h", done1, signature1, GOLD1);
        end
    endtask

    task automatic test_faults();
        for (int f = 0; f < 2; f++) begin
            faultStuck = (f == 0);
            faultZero  = (f == 1);
            start1 = 1'b1;
            tick();
            start1 = 1'b0;
            for (int t = 1; t <= 33; t++) tick();
            checks++;
            if (done1 !== 1'b1 || pass1 !== 1'b0 || signature1 !== modelSig(1, faultStuck, faultZero)) begin
                errors++;
                $display("[TB] FAIL fault_%0d: got done=%b pass=%b sig=%h, required 1/0/%h",
                         f, done1, pass1, signature1, modelSig(1, faultStuck, faultZero));
            end
        end
        faultStuck = 1'b0;
        faultZero  = 1'b0;
    endtask

    // Runs dutLong for the full 784 clocks, checking operands, vec_count and done timing.
    task automatic run_long(input string tag);
        logic [31:0] l, expA, expB;
        l = SEED; expA = '0; expB = '0;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int t = 1; t <= 784; t++) begin
            tick();
            if (t % 49 == 1) begin
                expA = l;
                expB = lfsrNext(l);
                l    = lfsrNext(expB);
                checks++;
                if (dataA3 !== expA || dataB3 !== expB) begin
                    errors++;
                    $display("[TB] FAIL %s_load t=%0d: got %h %h, required %h %h", tag, t, dataA3, dataB3, expA, expB);
                end
            end
            if (t % 49 == 48) begin
                checks++;
                if (dataA3 !== expA || dataB3 !== expB) begin
                    errors++;
                    $display("[TB] FAIL %s_hold t=%0d: got %h %h, required %h %h", tag, t, dataA3, dataB3, expA, expB);
                end
            end
            if (t % 49 == 0) begin
                checks++;
                if (vecCount3 !== 5'(t / 49)) begin
                    errors++;
                    $display("[TB] FAIL %s_vec_count t=%0d: got %0d, required %0d", tag, t, vecCount3, t / 49);
                end
            end
            if (t == 783) begin
                checks++;
                if (done3 !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL %s_early_done: got %b, required 0", tag, done3);
                end
            end
        end
        checks++;
        if (done3 !== 1'b1 || pass3 !== 1'b1 || signature3 !== GOLD16) begin
            errors++;
            $display("[TB] FAIL %s_final: got done=%b pass=%b sig=%h, required 1/1/%h", tag, done3, pass3, signature3, GOLD16);
        end
    endtask

    task automatic test_long_run();
        run_long("long");
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (vecCount3 !== 5'd16 || done3 !== 1'b1 || busy3 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL long_saturate: got vc=%0d done=%b busy=%b, required 16/1/0", vecCount3, done3, busy3);
        end
    endtask

    task automatic test_mid_reset();
        bit found;
        found = 1'b0;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            tick();
            if (vecCount3 == 5'd1 && {opcode3, aluSel3} == 4'd5) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL mid_reset_reach: got vc=%0d combo=%0d, required 1/5", vecCount3, {opcode3, aluSel3});
        end
        rst3_n = 1'b0;
        #1;
        checks++;
        if ({busy3, done3, pass3, signature3, vecCount3, dataA3, dataB3, opcode3, aluSel3} !== '0) begin
            errors++;
            $display("[TB] FAIL mid_reset_outputs: got busy=%b sig=%h vc=%0d A=%h op=%0d, required all zero",
                     busy3, signature3, vecCount3, dataA3, opcode3);
        end
        tick(); tick();
        rst3_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (busy3 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset_idle: got busy=%b, required 0", busy3);
        end
        run_long("rerun");
    endtask

    initial begin
        test_reset();
        test_idle();
        test_run_timing();
        test_start_busy();
        test_back_to_back();
        test_faults();
        test_long_run();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
